// File: rtl/ultra_pkg.sv
// Shared widths and types for the ultrasonic range-sample conditioner.
package ultra_pkg;

  localparam int SAMPLE_W = 8;
  localparam int AVG_LOG2 = 3;
  localparam int ACC_W    = SAMPLE_W + AVG_LOG2;

  typedef logic [SAMPLE_W-1:0] sample_t;
  typedef logic [ACC_W-1:0]    acc_t;

endpackage

// File: rtl/ultra_median3.sv
// Combinational median of three samples.
module ultra_median3
  import ultra_pkg::*;
(
  input  sample_t a,
  input  sample_t b,
  input  sample_t c,
  output sample_t med
);

  sample_t lo;
  sample_t hi;
  sample_t hi_c;

  assign lo   = (a < b) ? a : b;
  assign hi   = (a < b) ? b : a;
  assign hi_c = (hi < c) ? hi : c;
  assign med  = (lo > hi_c) ? lo : hi_c;

endmodule

// File: rtl/ultra_median_avg.sv
// Strobe synchronizer, 3-tap median window and
// block averager for ultrasonic range samples.
module ultra_median_avg
  import ultra_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [DATA_W-1:0] data_i,
  input  logic              data_av_ai,
  output sample_t           median_o,
  output logic              median_en_o,
  output sample_t           avg_o,
  output logic              avg_o_en
);

  logic [2:0] sync_q;
  logic       capture_p;
  sample_t    sample;
  sample_t    w0;
  sample_t    w1;
  sample_t    w2;
  logic       shift_q;
  sample_t    med;
  acc_t       acc;
  acc_t       acc_sum;
  logic [AVG_LOG2-1:0] cnt;

  // sync_q[1] is the synchronized strobe, sync_q[2] its history
  assign capture_p = sync_q[1] & ~sync_q[2];

  assign sample = (|data_i[DATA_W-1:SAMPLE_W]) ?
                  '1 : data_i[SAMPLE_W-1:0];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[1:0], data_av_ai};
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      w0      <= '0;
      w1      <= '0;
      w2      <= '0;
      shift_q <= 1'b0;
    end else begin
      shift_q <= capture_p;
      if (capture_p) begin
        w2 <= w1;
        w1 <= w0;
        w0 <= sample;
      end
    end
  end

  ultra_median3 u_med (
    .a   (w0),
    .b   (w1),
    .c   (w2),
    .med (med)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      median_o    <= '0;
      median_en_o <= 1'b0;
    end else begin
      median_en_o <= shift_q;
      if (shift_q) begin
        median_o <= med;
      end
    end
  end

  assign acc_sum = acc + acc_t'(median_o);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc      <= '0;
      cnt      <= '0;
      avg_o    <= '0;
      avg_o_en <= 1'b0;
    end else begin
      avg_o_en <= 1'b0;
      if (median_en_o) begin
        if (&cnt) begin
          avg_o    <= acc_sum[AVG_LOG2 +: SAMPLE_W];
          avg_o_en <= 1'b1;
          acc      <= '0;
          cnt      <= '0;
        end else begin
          acc <= acc_sum;
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ultra_median_avg.sv
// Self-checking bench for ultra_median_avg.
module tb_ultra_median_avg;

  logic        clk;
  logic        rstn;
  logic [15:0] data_i;
  logic        data_av_ai;
  logic [7:0]  median_o;
  logic        median_en_o;
  logic [7:0]  avg_o;
  logic        avg_o_en;

  int tests;
  int fails;

  int m_win[3];
  int m_blk[$];
  int m_avg;

  typedef struct {
    int data;
    int exp_med;
  } vec_t;

  vec_t vecs[8];

  ultra_median_avg #(.DATA_W(16)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .data_i      (data_i),
    .data_av_ai  (data_av_ai),
    .median_o    (median_o),
    .median_en_o (median_en_o),
    .avg_o       (avg_o),
    .avg_o_en    (avg_o_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int sat(input int d);
    return (d > 255) ? 255 : d;
  endfunction

  function automatic int med3(input int a, input int b, input int c);
    int q[$];
    q = '{a, b, c};
    q.sort();
    return q[1];
  endfunction

  task automatic model_reset();
    m_win = '{0, 0, 0};
    m_blk.delete();
    m_avg = 0;
  endtask

  task automatic model_push(input int d, output int em,
                            output bit av, output int ea);
    int sum;
    m_win[2] = m_win[1];
    m_win[1] = m_win[0];
    m_win[0] = sat(d);
    em = med3(m_win[0], m_win[1], m_win[2]);
    m_blk.push_back(em);
    av = 1'b0;
    ea = 0;
    if (m_blk.size() == 8) begin
      sum = 0;
      foreach (m_blk[i]) sum += m_blk[i];
      ea    = sum / 8;
      av    = 1'b1;
      m_avg = ea;
      m_blk.delete();
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn       = 1'b0;
    data_av_ai = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset avg_o", avg_o, 0);
    chk("reset median_o", median_o, 0);
    rstn = 1'b1;
    model_reset();
  endtask

  // One strobe of `hold` cycles; observes pulses for a bounded window.
  task automatic send(input int d, input int hold, output int got_med);
    int em, ea, npulse, navg, lat, mv, avv;
    bit av;
    model_push(d, em, av, ea);
    npulse = 0;
    navg   = 0;
    lat    = -1;
    mv     = -1;
    avv    = -1;
    @(negedge clk);
    data_i     = 16'(d);
    data_av_ai = 1'b1;
    for (int i = 1; i <= hold + 12; i++) begin
      @(negedge clk);
      if (i == hold) data_av_ai = 1'b0;
      if (median_en_o) begin
        npulse++;
        if (npulse == 1) begin
          lat = i;
          mv  = median_o;
        end
      end
      if (avg_o_en) begin
        navg++;
        avv = avg_o;
      end
    end
    got_med = mv;
    chk("median pulses", npulse, 1);
    chk("median latency", lat, 4);
    chk("median value", mv, em);
    chk("avg pulses", navg, av ? 1 : 0);
    if (av) chk("avg value", avv, ea);
    chk("avg held", avg_o, m_avg);
  endtask

  initial begin
    int gm;
    int npulse;
    tests      = 0;
    fails      = 0;
    rstn       = 1'b0;
    data_i     = '0;
    data_av_ai = 1'b0;
    model_reset();

    vecs[0] = '{150, 0};
    vecs[1] = '{100, 100};
    vecs[2] = '{10, 100};
    vecs[3] = '{40, 40};
    vecs[4] = '{250, 40};
    vecs[5] = '{110, 110};
    vecs[6] = '{35, 110};
    vecs[7] = '{200, 110};

    // Idle after reset: no pulses, outputs zero
    do_reset();
    npulse = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (median_en_o || avg_o_en) npulse++;
    end
    chk("idle pulses", npulse, 0);
    chk("idle avg_o", avg_o, 0);
    chk("idle median_o", median_o, 0);

    // Table of mixed samples
    do_reset();
    for (int i = 0; i < 8; i++) begin
      send(vecs[i].data, 1, gm);
      chk("table median", gm, vecs[i].exp_med);
    end
    chk("table avg", m_avg, 76);
    repeat (10) @(negedge clk);
    chk("table avg hold", avg_o, 76);

    // Saturation
    do_reset();
    for (int i = 0; i < 8; i++) send(300, 1, gm);
    chk("sat median", median_o, 255);
    chk("sat avg", avg_o, 223);

    // Long strobe gives a single capture
    do_reset();
    send(77, 10, gm);
    chk("long strobe median", gm, 0);

    // Two blocks of 8, then reset mid-block
    do_reset();
    for (int i = 0; i < 8; i++) send(8, 1, gm);
    chk("block1 avg", avg_o, 7);
    for (int i = 0; i < 8; i++) send(8, 1, gm);
    chk("block2 avg", avg_o, 8);
    for (int i = 0; i < 5; i++) send(90 + i * 20, 2, gm);
    do_reset();
    for (int i = 0; i < 8; i++) send(16, 1, gm);
    chk("post-reset avg", avg_o, 14);

    // Randomized samples against the model
    do_reset();
    for (int i = 0; i < 40; i++) begin
      send(int'($urandom_range(0, 400)),
           int'($urandom_range(1, 3)), gm);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
